// File: rtl/timer_display_poller_if.sv
// Bus between the timer display poller (initiator) and the timer peripheral.
// master: drives bus_addr, bus_w_r and bus_config, and samples bus_rdata.
// slave:  samples the request and drives bus_rdata.
interface timer_display_poller_if;
    logic [31:0] bus_addr;
    logic        bus_w_r;
    logic [31:0] bus_config;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_w_r,
        output bus_config,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_w_r,
        input  bus_config,
        output bus_rdata
    );
endinterface

// File: rtl/timer_display_poller.sv
// Timer display poller: turns start/stop buttons into timer config writes,
// polls the timer status word and shows mm.ss on a 4-digit 7-seg display.
// Ports: clk, rst (sync, active-high), start_btn, stop_btn,
//   bus (master modport: bus_addr, bus_w_r, bus_config out; bus_rdata in),
//   seconds_bcd, minutes_bcd, time_valid, seg (active-low, seg[7]=dp),
//   an (active-low digit enables), buzzer.
// Optional macro BEEP_PWM_EN: buzzer toggles every BEEP_DIV cycles while
//   beep is set; without it the buzzer follows the captured beep level.
module timer_display_poller #(
    parameter logic [31:0] TIMER_ADDR = 32'h0000_8000,
    parameter int          POLL_DIV   = 1000,
    parameter int          SCAN_DIV   = 100000,
    parameter int          BEEP_DIV   = 25000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_btn,
    input  logic                   stop_btn,
    timer_display_poller_if.master bus,
    output logic [7:0]             seconds_bcd,
    output logic [7:0]             minutes_bcd,
    output logic                   time_valid,
    output logic [7:0]             seg,
    output logic [3:0]             an,
    output logic                   buzzer
);

    localparam int PW = $clog2(POLL_DIV + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_HOLD = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_CAPT = 3'd4;

    localparam logic [6:0] DASH = 7'h3F;

    logic [2:0]    state;
    logic          start_q;
    logic          stop_q;
    logic          start_edge;
    logic          stop_edge;
    logic          pend_valid;
    logic          pend_start;
    logic          launch_wr;
    logic          launch_rd;
    logic          capture;
    logic [PW-1:0] poll_cnt;
    logic          poll_req;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [6:0]    glyph;
    logic          beep;
    logic          unused_rdata;

    assign unused_rdata = ^bus.bus_rdata[14:0];

    assign start_edge = start_btn & ~start_q;
    assign stop_edge  = stop_btn & ~stop_q;
    assign launch_wr  = (state == IDLE) && pend_valid;
    assign launch_rd  = (state == IDLE) && !pend_valid && poll_req;
    assign capture    = (state == RD_CAPT);

    // Single command slot. The slot is released when the write launches,
    // so an edge landing in that same cycle (or later) is kept for a
    // following write instead of being lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            pend_valid <= 1'b0;
            pend_start <= 1'b0;
        end else begin
            start_q <= start_btn;
            stop_q  <= stop_btn;
            if (stop_edge) begin
                pend_valid <= 1'b1;
                pend_start <= 1'b0;
            end else if (start_edge) begin
                pend_valid <= 1'b1;
                pend_start <= 1'b1;
            end else if (launch_wr) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt <= '0;
            poll_req <= 1'b0;
        end else begin
            if (poll_cnt == PW'(POLL_DIV - 1)) begin
                poll_cnt <= '0;
                poll_req <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + 1'b1;
                if (launch_rd) begin
                    poll_req <= 1'b0;
                end
            end
        end
    end

    // Bus outputs are loaded on entry to a transaction and dropped on exit,
    // which gives the two-cycle address hold the timer needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.bus_addr   <= '0;
            bus.bus_w_r    <= 1'b1;
            bus.bus_config <= '0;
            seconds_bcd    <= '0;
            minutes_bcd    <= '0;
            time_valid     <= 1'b0;
            beep           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        state          <= WR_ADDR;
                        bus.bus_addr   <= TIMER_ADDR;
                        bus.bus_w_r    <= 1'b0;
                        bus.bus_config <= {31'b0, pend_start};
                    end else if (poll_req) begin
                        state        <= RD_ADDR;
                        bus.bus_addr <= TIMER_ADDR;
                        bus.bus_w_r  <= 1'b1;
                    end
                end
                WR_ADDR: state <= WR_HOLD;
                WR_HOLD: begin
                    state        <= IDLE;
                    bus.bus_addr <= '0;
                    bus.bus_w_r  <= 1'b1;
                end
                RD_ADDR: state <= RD_CAPT;
                RD_CAPT: begin
                    state        <= IDLE;
                    bus.bus_addr <= '0;
                    seconds_bcd  <= bus.bus_rdata[31:24];
                    minutes_bcd  <= bus.bus_rdata[23:16];
                    beep         <= bus.bus_rdata[15];
                    time_valid   <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    bus.bus_addr <= '0;
                    bus.bus_w_r  <= 1'b1;
                end
            endcase
        end
    end

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return DASH;
        endcase
    endfunction

    // The timer encodes 50-59 with a tens nibble of 6.
    function automatic logic [6:0] tens_glyph(input logic [3:0] d);
        if (d <= 4'd4) begin
            return font(d);
        end else if (d == 4'd6) begin
            return font(4'd5);
        end
        return DASH;
    endfunction

    always_comb begin
        glyph = DASH;
        case (idx)
            2'd0: glyph = font(seconds_bcd[3:0]);
            2'd1: glyph = tens_glyph(seconds_bcd[7:4]);
            2'd2: glyph = font(minutes_bcd[3:0]);
            2'd3: glyph = tens_glyph(minutes_bcd[7:4]);
            default: glyph = DASH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            seg      <= 8'hFF;
            an       <= 4'hF;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an <= ~(4'b0001 << idx);
            if (time_valid) begin
                seg <= {(idx != 2'd2), glyph};
            end else begin
                seg <= 8'hBF;
            end
        end
    end

`ifdef BEEP_PWM_EN
    localparam int BW = $clog2(BEEP_DIV + 1);

    logic [BW-1:0] beep_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            beep_cnt <= '0;
            buzzer   <= 1'b0;
        end else if (capture && bus.bus_rdata[15] && !beep) begin
            beep_cnt <= '0;
            buzzer   <= 1'b1;
        end else if ((capture && !bus.bus_rdata[15]) || (!capture && !beep)) begin
            beep_cnt <= '0;
            buzzer   <= 1'b0;
        end else if (beep_cnt == BW'(BEEP_DIV - 1)) begin
            beep_cnt <= '0;
            buzzer   <= ~buzzer;
        end else begin
            beep_cnt <= beep_cnt + 1'b1;
        end
    end
`else
    localparam int unused_beep_div = BEEP_DIV;

    logic unused_capture;

    assign unused_capture = capture;
    assign buzzer         = beep;
`endif

endmodule

// File: tb/tb_timer_display_poller.sv
// Self-checking bench for timer_display_poller: directed steps with random
// status words, checked against a behavioural display/bus model.
module tb_timer_display_poller;

    localparam logic [31:0] TADDR = 32'h0000_8000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic       stop_btn;
    logic [7:0] seconds_bcd;
    logic [7:0] minutes_bcd;
    logic       time_valid;
    logic [7:0] seg;
    logic [3:0] an;
    logic       buzzer;

    int tests = 0;
    int fails = 0;

    logic [6:0] font_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    timer_display_poller_if bus_if ();

    timer_display_poller #(
        .TIMER_ADDR (TADDR),
        .POLL_DIV   (8),
        .SCAN_DIV   (4),
        .BEEP_DIV   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_btn   (start_btn),
        .stop_btn    (stop_btn),
        .bus         (bus_if),
        .seconds_bcd (seconds_bcd),
        .minutes_bcd (minutes_bcd),
        .time_valid  (time_valid),
        .seg         (seg),
        .an          (an),
        .buzzer      (buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a transaction of the given direction, then counts
    // the cycles its address stays on the bus. len = 0 means none was seen.
    task automatic wait_txn(input logic want_wr, input int limit,
                            output int len, output logic [31:0] cfg);
        int n;
        n = 0;
        len = 0;
        cfg = '0;
        while (!(bus_if.bus_addr != 0 && bus_if.bus_w_r == want_wr)
               && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n < limit) begin
            cfg = bus_if.bus_config;
            while (bus_if.bus_addr == TADDR && bus_if.bus_w_r == want_wr
                   && len < 10) begin
                len++;
                @(negedge clk);
            end
        end
    endtask

    function automatic int an_index(input logic [3:0] a);
        for (int i = 0; i < 4; i++) begin
            if (a == ~(4'b0001 << i)) return i;
        end
        return -1;
    endfunction

    function automatic logic [6:0] glyph_ref(input logic [3:0] n,
                                             input bit tens);
        if (!tens) return (n < 10) ? font_ref[n] : 7'h3F;
        if (n < 5) return font_ref[n];
        if (n == 6) return font_ref[5];
        return 7'h3F;
    endfunction

    function automatic logic [7:0] seg_ref(input logic [3:0] a,
                                           input logic [7:0] s,
                                           input logic [7:0] m);
        int i;
        i = an_index(a);
        case (i)
            0: return {1'b1, glyph_ref(s[3:0], 1'b0)};
            1: return {1'b1, glyph_ref(s[7:4], 1'b1)};
            2: return {1'b0, glyph_ref(m[3:0], 1'b0)};
            3: return {1'b1, glyph_ref(m[7:4], 1'b1)};
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        int          len;
        int          n;
        int          idx0;
        logic [31:0] cfg;
        logic [31:0] val;
        logic [31:0] r;
        logic [3:0]  prev;
        logic [3:0]  exp_an;

        rst = 1'b1;
        start_btn = 1'b0;
        stop_btn = 1'b0;
        bus_if.bus_rdata = 32'h1234_8000;
        repeat (3) @(negedge clk);
        chk("rst_addr", bus_if.bus_addr, 0);
        chk("rst_w_r", bus_if.bus_w_r, 1);
        chk("rst_cfg", bus_if.bus_config, 0);
        chk("rst_sec", seconds_bcd, 0);
        chk("rst_min", minutes_bcd, 0);
        chk("rst_valid", time_valid, 0);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_an", an, 4'hF);
        chk("rst_buzz", buzzer, 0);

        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("inval_valid", time_valid, 0);
        chk("inval_seg", seg, 8'hBF);

        wait_txn(1'b1, 30, len, cfg);
        chk("rd1_len", len, 2);
        chk("rd1_idle", bus_if.bus_addr, 0);
        chk("rd1_sec", seconds_bcd, 8'h12);
        chk("rd1_min", minutes_bcd, 8'h34);
        chk("rd1_valid", time_valid, 1);
        chk("rd1_buzz", buzzer, 1);

        prev = an;
        n = 0;
        while (an == prev && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("scan_moves", (n < 10), 1);
        idx0 = an_index(an);
        if (idx0 < 0) idx0 = 0;
        for (int k = 0; k < 20; k++) begin
            exp_an = ~(4'b0001 << ((idx0 + k / 4) % 4));
            chk("scan_an", an, exp_an);
            chk("scan_dp", seg[7], (exp_an == 4'b1011) ? 1'b0 : 1'b1);
            @(negedge clk);
        end

        start_btn = 1'b1;
        wait_txn(1'b0, 30, len, cfg);
        chk("wr_start_len", len, 2);
        chk("wr_start_cfg", cfg, 1);
        chk("wr_start_idle", bus_if.bus_addr, 0);
        start_btn = 1'b0;
        @(negedge clk);
        stop_btn = 1'b1;
        wait_txn(1'b0, 30, len, cfg);
        chk("wr_stop_len", len, 2);
        chk("wr_stop_cfg", cfg, 0);
        stop_btn = 1'b0;

        n = 0;
        while (!(bus_if.bus_addr == TADDR && bus_if.bus_w_r) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("both_rd_seen", (n < 30), 1);
        start_btn = 1'b1;
        stop_btn = 1'b1;
        @(negedge clk);
        chk("both_rd_hold", bus_if.bus_addr, TADDR);
        chk("both_rd_w_r", bus_if.bus_w_r, 1);
        @(negedge clk);
        chk("both_rd_done", bus_if.bus_addr, 0);
        wait_txn(1'b0, 30, len, cfg);
        chk("both_wr_len", len, 2);
        chk("both_wr_cfg", cfg, 0);
        wait_txn(1'b0, 24, len, cfg);
        chk("both_single_wr", len, 0);
        start_btn = 1'b0;
        stop_btn = 1'b0;

        for (int i = 0; i < 8; i++) begin
            r = $urandom();
            if (i == 0) val = 32'h6500_8000;
            else if (i == 1) val = 32'h7500_8000;
            else val = {r[31:15], 15'b0};
            bus_if.bus_rdata = val;
            wait_txn(1'b1, 30, len, cfg);
            chk("rnd_rd_len", len, 2);
            chk("rnd_sec", seconds_bcd, val[31:24]);
            chk("rnd_min", minutes_bcd, val[23:16]);
            chk("rnd_buzz", buzzer, val[15]);
            @(negedge clk);
            for (int k = 0; k < 16; k++) begin
                chk("rnd_seg", seg, seg_ref(an, val[31:24], val[23:16]));
                if (i == 0 && an == 4'b1101) chk("sec50_seg", seg, 8'h92);
                if (i == 1 && an == 4'b1101) chk("sec75_seg", seg, 8'hBF);
                @(negedge clk);
            end
        end

        bus_if.bus_rdata = 32'h5959_8000;
        n = 0;
        while (!(bus_if.bus_addr == TADDR && bus_if.bus_w_r) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rstcap_rd_seen", (n < 30), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstcap_addr", bus_if.bus_addr, 0);
        chk("rstcap_w_r", bus_if.bus_w_r, 1);
        chk("rstcap_sec", seconds_bcd, 0);
        chk("rstcap_valid", time_valid, 0);
        chk("rstcap_an", an, 4'hF);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_display_poller.md
Name: timer_display_poller

Overview:
- Bus initiator that sits on the CPU-side peripheral bus opposite the timer peripheral at 0x0000_8000.
- Turns debounced start/stop buttons into timer config writes.
- Periodically reads the timer status word, decodes its BCD seconds/minutes and beep flag, and drives a 4-digit multiplexed 7-segment display and a buzzer.

Parameters:
- TIMER_ADDR, 32'h0000_8000, address of the timer peripheral.
- POLL_DIV, 1000, clk cycles between read requests (min 4).
- SCAN_DIV, 100000, clk cycles each display digit is enabled (min 1).
- BEEP_DIV, 25000, buzzer half-period in cycles; used only with BEEP_PWM_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start_btn  in  1  debounced level; rising edge requests timer start.
- stop_btn  in  1  debounced level; rising edge requests timer stop.
- bus_addr  out  32  bus address.
- bus_w_r  out  1  0 = config write, 1 = read.
- bus_config  out  32  config word; bit0 = run.
- bus_rdata  in  32  timer status {sec_bcd[31:24], min_bcd[23:16], beep[15], 15'b0}; Z when not addressed.
- seconds_bcd  out  8  last captured seconds.
- minutes_bcd  out  8  last captured minutes.
- time_valid  out  1  high once any read has been captured.
- seg  out  8  active-low segments; seg[6:0] = g..a, seg[7] = dp.
- an  out  4  active-low digit enables.
- buzzer  out  1  buzzer drive.

Behaviour:
- All outputs are registered on posedge clk.
- Reset values: bus_addr 0, bus_w_r 1, bus_config 0, seconds_bcd 0, minutes_bcd 0, time_valid 0, seg 8'hFF, an 4'hF, buzzer 0. Pending command, poll request and all counters are cleared.
- Bus idle state: bus_addr = 0, bus_w_r = 1, bus_config holds its last value.
- Button edges: rising edges are detected against a registered copy of each button.
  - A start edge sets pending = START; a stop edge sets pending = STOP.
  - Both edges in the same cycle give STOP.
  - There is one pending slot; a newer edge overwrites an unserviced command.
- Poll counter: free-runs 0..POLL_DIV-1. At terminal count it sets poll_req, which holds until serviced.
- FSM states and transitions:
  - IDLE: if a command is pending, go to WR_ADDR; otherwise if poll_req, go to RD_ADDR. A pending command wins over a poll request.
  - WR_ADDR: bus_addr = TIMER_ADDR, bus_w_r = 0, bus_config = {31'b0, cmd==START}. Clear pending. Go to WR_HOLD.
  - WR_HOLD: hold the bus values for a second cycle. Go to IDLE, where the bus returns to idle.
  - RD_ADDR: bus_addr = TIMER_ADDR, bus_w_r = 1. Clear poll_req. Go to RD_CAPT.
  - RD_CAPT: address held. At the end of this cycle capture seconds_bcd <= bus_rdata[31:24], minutes_bcd <= bus_rdata[23:16], beep <= bus_rdata[15], and set time_valid <= 1. Go to IDLE.
- Read latency: poll_req seen in IDLE at cycle N gives address out at N+1 and N+2, captured values visible at N+3, bus idle at N+3.
- The two-cycle hold is mandatory: the timer samples on the falling edge and updates its status only after the first addressed half-cycle.
- Button edges arriving during a transaction are queued and never dropped mid-transaction.
- Digit decode:
  - Digit 3 = minutes tens, digit 2 = minutes ones, digit 1 = seconds tens, digit 0 = seconds ones.
  - Ones nibble: 0-9 show the digit; A-F show a dash (segment g only).
  - Tens nibble: 0-4 show the digit; 6 shows '5' (the timer encodes 50-59 with tens nibble 4'h6); 5 and 7-F show a dash.
- Display scan:
  - Scan counter 0..SCAN_DIV-1; on wrap, the digit index advances 0→1→2→3→0.
  - an = ~(1<<idx).
  - dp is lit (seg[7] = 0) only while idx = 2.
  - While time_valid = 0, seg = 8'hBF (dash) on every digit.
- Buzzer (base behaviour): buzzer = captured beep.
- Reset mid-transaction: the transaction is aborted and the bus is idle on the next cycle. No capture occurs and no partial write is retried.

Optional Feature:
- BEEP_PWM_EN defined: while beep = 1, buzzer toggles every BEEP_DIV cycles, starting high on the first cycle after beep is captured as 1. While beep = 0, buzzer = 0 and the toggle counter is held at 0.
- BEEP_PWM_EN undefined: buzzer = beep level; no toggle counter is instantiated.

Test Plan:
- Reset, bus_rdata = 32'h1234_8000, POLL_DIV = 8 → after the first read: seconds_bcd = 8'h12, minutes_bcd = 8'h34, time_valid = 1, buzzer = 1 (feature off); bus_addr = 0x8000 for exactly 2 cycles.
- Single start_btn rise → bus_addr = 0x8000, bus_w_r = 0, bus_config = 1 for exactly 2 cycles, then idle. A stop_btn rise then gives bus_config = 0.
- start_btn and stop_btn rise in the same cycle while a read is in RD_ADDR → the read completes, then exactly one write with bus_config = 0.
- bus_rdata[31:24] = 8'h65 → digit 1 shows '5' (seg = 8'h92 when idx ≠ 2). With 8'h75 → dash (8'hBF).
- SCAN_DIV = 4 → an sequence 1110, 1101, 1011, 0111 with each held 4 cycles, then wrap; seg[7] = 0 only while an = 1011.
- rst asserted during RD_CAPT with bus_rdata = 32'h5959_8000 → next cycle bus idle, seconds_bcd = 0, time_valid = 0, an = 4'hF.
